ram_act_banked: RTL and testbench



---
 rtl/ram_act_banked_pkg.sv | 41 ++++
 rtl/ram_act_banked_if.sv | 35 +++
 rtl/ram_act_banked_bank.sv | 37 +++
 rtl/ram_act_banked.sv | 162 ++++++++++++++++
 tb/tb_ram_act_banked.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_act_banked_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg : address-split helpers and parameter checks for ram_act_banked. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int row_bits(input int words);
    return (clog2(words) < 1) ? 1 : clog2(words);
  endfunction

  function automatic int addr_width(input int words, input int num_bank);
    return clog2(num_bank) + row_bits(words);
  endfunction

  // Banks are interleaved on the low address bits.
  function automatic int bank_of(input int addr, input int num_bank);
    return addr & (num_bank - 1);
  endfunction

  function automatic int row_of(input int addr, input int num_bank);
    return addr >> clog2(num_bank);
  endfunction

  function automatic bit params_ok(input int data_w, input int byte_w,
                                   input int num_bank, input int read_lat);
    return (read_lat == 1 || read_lat == 2) && (byte_w > 0) &&
           (data_w % byte_w == 0) && (num_bank >= 1) &&
           ((num_bank & (num_bank - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_act_banked_if.sv
// ---------------------------------------------------------------------------
// ram_act_banked_if : independent read and write request ports. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ram_act_banked_if
  import ram_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int NUM_BYTE = 16,
  parameter int ADDR_W   = addr_width(64, 2)
);
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_gnt;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_BYTE-1:0] wr_be;
  logic                wr_gnt;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_valid, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_valid, rd_data, wr_gnt
  );
endinterface

`default_nettype wire

// File: rtl/ram_act_banked_bank.sv
// ---------------------------------------------------------------------------
// sp_sram_bank : behavioural single-port bank, byte-lane writes, 1-cycle read. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sp_sram_bank #(
  parameter int DATA_W   = 128,
  parameter int BYTE_W   = 8,
  parameter int NUM_BYTE = DATA_W / BYTE_W,
  parameter int WORDS    = 64,
  parameter int ROW_W    = 6
) (
  input  logic                clk,
  input  logic                cs,
  input  logic                we,
  input  logic [NUM_BYTE-1:0] be,
  input  logic [ROW_W-1:0]    row,
  input  logic [DATA_W-1:0]   di,
  output logic [DATA_W-1:0]   dout
);
  logic [DATA_W-1:0] mem [WORDS];

  // Output keeps its last read value across writes and idle cycles, like the macro.
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int i = 0; i < NUM_BYTE; i++) begin
          if (be[i]) mem[row][i*BYTE_W +: BYTE_W] <= di[i*BYTE_W +: BYTE_W];
        end
      end else begin
        dout <= mem[row];
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/ram_act_banked.sv
// ---------------------------------------------------------------------------
// ram_act_banked : banked activation RAM with posted-write collision buffer. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_act_banked
  import ram_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int BYTE_W   = 8,
  parameter int WORDS    = 64,
  parameter int NUM_BANK = 2,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  ram_act_banked_if.slave  bus
);
  localparam int NUM_BYTE = DATA_W / BYTE_W;
  localparam int ROW_W    = row_bits(WORDS);
  localparam int BSEL_W   = (clog2(NUM_BANK) < 1) ? 1 : clog2(NUM_BANK);

  if (!params_ok(DATA_W, BYTE_W, NUM_BANK, READ_LAT)) begin : g_bad_params
    $error("ram_act_banked: illegal DATA_W/BYTE_W/NUM_BANK/READ_LAT combination");
  end

  logic [BSEL_W-1:0] rd_bank, wr_bank, wb_bank, rd_p1_bank;
  logic [ROW_W-1:0]  rd_row, wr_row, wb_row;
  logic              rd_oor, wr_oor, rd_p1_oor, rd_p1_v;
  logic              wb_v, rd_stall_q;
  logic [DATA_W-1:0]   wb_data, rd_word;
  logic [NUM_BYTE-1:0] wb_be;
  logic drain, rd_gnt, wr_gnt, wr_conflict, wr_direct, wr_load, rd_ret;

  logic [NUM_BANK-1:0]               bank_cs, bank_we;
  logic [NUM_BANK-1:0][NUM_BYTE-1:0] bank_be;
  logic [NUM_BANK-1:0][ROW_W-1:0]    bank_row;
  logic [NUM_BANK-1:0][DATA_W-1:0]   bank_di, bank_do;

  always_comb begin
    rd_bank = BSEL_W'(bank_of(int'(bus.rd_addr), NUM_BANK));
    rd_row  = ROW_W'(row_of(int'(bus.rd_addr), NUM_BANK));
    rd_oor  = (row_of(int'(bus.rd_addr), NUM_BANK) >= WORDS);
    wr_bank = BSEL_W'(bank_of(int'(bus.wr_addr), NUM_BANK));
    wr_row  = ROW_W'(row_of(int'(bus.wr_addr), NUM_BANK));
    wr_oor  = (row_of(int'(bus.wr_addr), NUM_BANK) >= WORDS);
  end

  // Drain owns its bank; the read yields to it; the write yields to a read stalled last cycle.
  always_comb begin
    drain       = wb_v & ~rst;
    rd_gnt      = ~rst & bus.rd_req & ~(wb_v & (rd_bank == wb_bank));
    wr_gnt      = ~rst & bus.wr_req & ~(rd_stall_q & (wr_bank == rd_bank));
    wr_conflict = (wb_v & (wr_bank == wb_bank)) |
                  (rd_gnt & ~rd_oor & (rd_bank == wr_bank));
    wr_direct   = wr_gnt & ~wr_oor & ~wr_conflict;
    wr_load     = wr_gnt & ~wr_oor & wr_conflict;
  end

  assign bus.rd_gnt = rd_gnt;
  assign bus.wr_gnt = wr_gnt;

  always_comb begin
    bank_cs  = '0;
    bank_we  = '0;
    bank_be  = '0;
    bank_row = '0;
    bank_di  = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (drain && wb_bank == BSEL_W'(b)) begin
        bank_cs[b]  = 1'b1;
        bank_we[b]  = 1'b1;
        bank_be[b]  = wb_be;
        bank_row[b] = wb_row;
        bank_di[b]  = wb_data;
      end else if (wr_direct && wr_bank == BSEL_W'(b)) begin
        bank_cs[b]  = 1'b1;
        bank_we[b]  = 1'b1;
        bank_be[b]  = bus.wr_be;
        bank_row[b] = wr_row;
        bank_di[b]  = bus.wr_data;
      end else if (rd_gnt && !rd_oor && rd_bank == BSEL_W'(b)) begin
        bank_cs[b]  = 1'b1;
        bank_row[b] = rd_row;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    sp_sram_bank #(
      .DATA_W  (DATA_W),
      .BYTE_W  (BYTE_W),
      .NUM_BYTE(NUM_BYTE),
      .WORDS   (WORDS),
      .ROW_W   (ROW_W)
    ) u_bank (
      .clk (clk),
      .cs  (bank_cs[b]),
      .we  (bank_we[b]),
      .be  (bank_be[b]),
      .row (bank_row[b]),
      .di  (bank_di[b]),
      .dout(bank_do[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_v       <= 1'b0;
      rd_stall_q <= 1'b0;
      rd_p1_v    <= 1'b0;
    end else begin
      wb_v       <= wr_load;
      rd_stall_q <= bus.rd_req & ~rd_gnt;
      rd_p1_v    <= rd_gnt;
    end
    if (wr_load) begin
      wb_bank <= wr_bank;
      wb_row  <= wr_row;
      wb_data <= bus.wr_data;
      wb_be   <= bus.wr_be;
    end
    if (rd_gnt) begin
      rd_p1_bank <= rd_bank;
      rd_p1_oor  <= rd_oor;
    end
  end

  always_comb begin
    rd_word = '0;
    if (!rd_p1_oor) rd_word = bank_do[rd_p1_bank];
  end

  // A return landing while rst is high belongs to a discarded request.
  assign rd_ret = rd_p1_v & ~rst;

  if (READ_LAT == 1) begin : g_lat1
    logic [DATA_W-1:0] hold_q;
    always_ff @(posedge clk) begin
      if (rst)         hold_q <= '0;
      else if (rd_ret) hold_q <= rd_word;
    end
    assign bus.rd_valid = rd_ret;
    assign bus.rd_data  = rd_ret ? rd_word : hold_q;
  end else begin : g_lat2
    logic              rd_p2_v;
    logic [DATA_W-1:0] out_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_p2_v <= 1'b0;
        out_q   <= '0;
      end else begin
        rd_p2_v <= rd_p1_v;
        if (rd_p1_v) out_q <= rd_word;
      end
    end
    assign bus.rd_valid = rd_p2_v & ~rst;
    assign bus.rd_data  = out_q;
  end
endmodule

`default_nettype wire

// File: tb/tb_ram_act_banked.sv
// ---------------------------------------------------------------------------
// tb_ram_act_banked : directed bench driving READ_LAT=1 and READ_LAT=2 copies in lockstep. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_act_banked;
  import ram_pkg::*;

  localparam int DW    = 128;
  localparam int NB    = 16;
  localparam int WORDS = 49;
  localparam int BANKS = 2;
  localparam int AW    = addr_width(WORDS, BANKS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  ram_act_banked_if #(.DATA_W(DW), .NUM_BYTE(NB), .ADDR_W(AW)) bus1();
  ram_act_banked_if #(.DATA_W(DW), .NUM_BYTE(NB), .ADDR_W(AW)) bus2();

  ram_act_banked #(.DATA_W(DW), .BYTE_W(8), .WORDS(WORDS), .NUM_BANK(BANKS), .READ_LAT(1))
    u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
  ram_act_banked #(.DATA_W(DW), .BYTE_W(8), .WORDS(WORDS), .NUM_BANK(BANKS), .READ_LAT(2))
    u_lat2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {NB{b}};
  endfunction

  task automatic set_in(input logic rq, input logic [AW-1:0] ra, input logic wq,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NB-1:0] be);
    bus1.rd_req = rq; bus1.rd_addr = ra; bus1.wr_req = wq;
    bus1.wr_addr = wa; bus1.wr_data = wd; bus1.wr_be = be;
    bus2.rd_req = rq; bus2.rd_addr = ra; bus2.wr_req = wq;
    bus2.wr_addr = wa; bus2.wr_data = wd; bus2.wr_be = be;
  endtask

  // One cycle of stimulus; returns mid-cycle so outputs can be sampled.
  task automatic drive(input logic rq, input logic [AW-1:0] ra, input logic wq,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NB-1:0] be);
    @(posedge clk); #1;
    set_in(rq, ra, wq, wa, wd, be);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(1'b1, 7'd4, 1'b1, 7'd5, fill(8'hEE), '1);
    n_checks++;
    if ({bus1.rd_gnt, bus1.wr_gnt, bus1.rd_valid, bus2.rd_gnt, bus2.wr_gnt, bus2.rd_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus1.rd_gnt, bus1.wr_gnt, bus1.rd_valid, bus2.rd_gnt, bus2.wr_gnt, bus2.rd_valid});
    end
    n_checks++;
    if ({bus1.rd_data, bus2.rd_data} !== {2*DW{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_data: got %h / %h want 0", bus1.rd_data, bus2.rd_data);
    end
    set_in(1'b0, '0, 1'b0, '0, '0, '0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      idle();
      n_checks++;
      if ({bus1.rd_gnt, bus1.wr_gnt, bus1.rd_valid, bus2.rd_gnt, bus2.wr_gnt, bus2.rd_valid,
           bus1.rd_data, bus2.rd_data} !== {6'b0, {2*DW{1'b0}}}) begin
        n_fail++;
        $display("FAIL idle_after_reset c%0d: ctrl %b data %h / %h want all 0", c,
                 {bus1.rd_gnt, bus1.wr_gnt, bus1.rd_valid, bus2.rd_gnt, bus2.wr_gnt, bus2.rd_valid},
                 bus1.rd_data, bus2.rd_data);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b0, '0, 1'b1, 7'd4, fill(8'hA5), '1);
    n_checks++;
    if ({bus1.wr_gnt, bus2.wr_gnt} !== 2'b11) begin
      n_fail++; $display("FAIL wr4_gnt: got %b want 11", {bus1.wr_gnt, bus2.wr_gnt});
    end
    drive(1'b1, 7'd4, 1'b0, '0, '0, '0);
    n_checks++;
    if ({bus1.rd_gnt, bus2.rd_gnt} !== 2'b11) begin
      n_fail++; $display("FAIL rd4_gnt: got %b want 11", {bus1.rd_gnt, bus2.rd_gnt});
    end
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus2.rd_valid, bus1.rd_data} !== {2'b10, fill(8'hA5)}) begin
      n_fail++; $display("FAIL rd4_lat1: valid %b data %h want 10 / a5..",
                         {bus1.rd_valid, bus2.rd_valid}, bus1.rd_data);
    end
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus2.rd_valid, bus1.rd_data, bus2.rd_data} !==
        {2'b01, fill(8'hA5), fill(8'hA5)}) begin
      n_fail++; $display("FAIL rd4_lat2: valid %b data %h / %h want 01 / a5..",
                         {bus1.rd_valid, bus2.rd_valid}, bus1.rd_data, bus2.rd_data);
    end
    for (int c = 0; c < 5; c++) begin
      idle();
      n_checks++;
      if ({bus1.rd_valid, bus2.rd_valid, bus1.rd_data, bus2.rd_data} !==
          {2'b00, fill(8'hA5), fill(8'hA5)}) begin
        n_fail++; $display("FAIL rd4_hold c%0d: valid %b data %h / %h want 00 / a5..", c,
                           {bus1.rd_valid, bus2.rd_valid}, bus1.rd_data, bus2.rd_data);
      end
    end
  endtask

  task automatic test_collision();
    drive(1'b0, '0, 1'b1, 7'd2, fill(8'h11), '1);
    drive(1'b1, 7'd2, 1'b1, 7'd2, fill(8'h22), '1);
    n_checks++;
    if ({bus1.rd_gnt, bus1.wr_gnt, bus2.rd_gnt, bus2.wr_gnt} !== 4'b1111) begin
      n_fail++; $display("FAIL coll_gnt: got %b want 1111",
                         {bus1.rd_gnt, bus1.wr_gnt, bus2.rd_gnt, bus2.wr_gnt});
    end
    drive(1'b1, 7'd2, 1'b0, '0, '0, '0);
    n_checks++;
    if ({bus1.rd_gnt, bus2.rd_gnt, bus1.rd_valid, bus2.rd_valid, bus1.rd_data} !==
        {4'b0010, fill(8'h11)}) begin
      n_fail++; $display("FAIL coll_stall: gnt/valid %b data %h want 0010 / 11..",
                         {bus1.rd_gnt, bus2.rd_gnt, bus1.rd_valid, bus2.rd_valid}, bus1.rd_data);
    end
    drive(1'b1, 7'd2, 1'b0, '0, '0, '0);
    n_checks++;
    if ({bus1.rd_gnt, bus2.rd_gnt, bus1.rd_valid, bus2.rd_valid, bus1.rd_data, bus2.rd_data} !==
        {4'b1101, fill(8'h11), fill(8'h11)}) begin
      n_fail++; $display("FAIL coll_regrant: gnt/valid %b data %h / %h want 1101 / 11..",
                         {bus1.rd_gnt, bus2.rd_gnt, bus1.rd_valid, bus2.rd_valid},
                         bus1.rd_data, bus2.rd_data);
    end
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus2.rd_valid, bus1.rd_data} !== {2'b10, fill(8'h22)}) begin
      n_fail++; $display("FAIL coll_new_lat1: valid %b data %h want 10 / 22..",
                         {bus1.rd_valid, bus2.rd_valid}, bus1.rd_data);
    end
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus2.rd_valid, bus2.rd_data} !== {2'b01, fill(8'h22)}) begin
      n_fail++; $display("FAIL coll_new_lat2: valid %b data %h want 01 / 22..",
                         {bus1.rd_valid, bus2.rd_valid}, bus2.rd_data);
    end
  endtask

  task automatic test_diff_banks();
    int cnt1, cnt2, bad, gbad;
    cnt1 = 0; cnt2 = 0; bad = 0; gbad = 0;
    drive(1'b0, '0, 1'b1, 7'd0, fill(8'h33), '1);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 7'd0, 1'b1, 7'd1, fill(8'(8'h40 + i)), '1);
      else       idle();
      if (i < 8 && {bus1.rd_gnt, bus1.wr_gnt, bus2.rd_gnt, bus2.wr_gnt} !== 4'b1111) gbad++;
      if (bus1.rd_valid) begin cnt1++; if (bus1.rd_data !== fill(8'h33)) bad++; end
      if (bus2.rd_valid) begin cnt2++; if (bus2.rd_data !== fill(8'h33)) bad++; end
    end
    n_checks++;
    if (gbad != 0 || cnt1 != 8 || cnt2 != 8 || bad != 0) begin
      n_fail++; $display("FAIL diff_banks: gnt_miss %0d pulses %0d/%0d bad_data %0d want 0 8/8 0",
                         gbad, cnt1, cnt2, bad);
    end
    drive(1'b1, 7'd1, 1'b0, '0, '0, '0);
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus1.rd_data} !== {1'b1, fill(8'h47)}) begin
      n_fail++; $display("FAIL diff_last_wr_lat1: valid %b data %h want 1 / 47..",
                         bus1.rd_valid, bus1.rd_data);
    end
    idle();
    n_checks++;
    if ({bus2.rd_valid, bus2.rd_data} !== {1'b1, fill(8'h47)}) begin
      n_fail++; $display("FAIL diff_last_wr_lat2: valid %b data %h want 1 / 47..",
                         bus2.rd_valid, bus2.rd_data);
    end
  endtask

  task automatic test_starvation();
    // {rd_gnt, wr_gnt}: buffered, drain stall, guard holds write, read granted, buffered again
    logic [1:0] exp_g [5] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 7'd0, 1'b1, 7'd0, fill(8'h5A), '1);
      n_checks++;
      if ({bus1.rd_gnt, bus1.wr_gnt, bus2.rd_gnt, bus2.wr_gnt} !== {exp_g[c], exp_g[c]}) begin
        n_fail++; $display("FAIL starve c%0d: got %b want %b", c,
                           {bus1.rd_gnt, bus1.wr_gnt, bus2.rd_gnt, bus2.wr_gnt}, {exp_g[c], exp_g[c]});
      end
    end
    repeat (3) idle();
  endtask

  task automatic test_byte_en_bounds();
    drive(1'b0, '0, 1'b1, 7'd6, '0, '1);
    drive(1'b0, '0, 1'b1, 7'd6, fill(8'hFF), 16'h0001);
    drive(1'b0, '0, 1'b1, 7'd6, fill(8'h77), 16'h0000);
    n_checks++;
    if ({bus1.wr_gnt, bus2.wr_gnt} !== 2'b11) begin
      n_fail++; $display("FAIL be_zero_gnt: got %b want 11", {bus1.wr_gnt, bus2.wr_gnt});
    end
    drive(1'b1, 7'd6, 1'b0, '0, '0, '0);
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus1.rd_data} !== {1'b1, 120'h0, 8'hFF}) begin
      n_fail++; $display("FAIL byte_en_lat1: valid %b data %h want 1 / 0..0ff", bus1.rd_valid, bus1.rd_data);
    end
    idle();
    n_checks++;
    if ({bus2.rd_valid, bus2.rd_data} !== {1'b1, 120'h0, 8'hFF}) begin
      n_fail++; $display("FAIL byte_en_lat2: valid %b data %h want 1 / 0..0ff", bus2.rd_valid, bus2.rd_data);
    end
    // Address 97 is the last in-range row (48) of bank 1; 98 is row 49 of bank 0.
    drive(1'b0, '0, 1'b1, 7'd97, fill(8'h99), '1);
    drive(1'b0, '0, 1'b1, 7'd98, fill(8'hDD), '1);
    n_checks++;
    if ({bus1.wr_gnt, bus2.wr_gnt} !== 2'b11) begin
      n_fail++; $display("FAIL oor_wr_gnt: got %b want 11", {bus1.wr_gnt, bus2.wr_gnt});
    end
    drive(1'b1, 7'd97, 1'b0, '0, '0, '0);
    drive(1'b1, 7'd98, 1'b0, '0, '0, '0);
    n_checks++;
    if ({bus1.rd_gnt, bus2.rd_gnt, bus1.rd_valid, bus2.rd_valid, bus1.rd_data} !==
        {4'b1110, fill(8'h99)}) begin
      n_fail++; $display("FAIL last_row: gnt/valid %b data %h want 1110 / 99..",
                         {bus1.rd_gnt, bus2.rd_gnt, bus1.rd_valid, bus2.rd_valid}, bus1.rd_data);
    end
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus2.rd_valid, bus1.rd_data, bus2.rd_data} !==
        {2'b11, {DW{1'b0}}, fill(8'h99)}) begin
      n_fail++; $display("FAIL oor_rd_lat1: valid %b data %h / %h want 11 / 0 / 99..",
                         {bus1.rd_valid, bus2.rd_valid}, bus1.rd_data, bus2.rd_data);
    end
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus2.rd_valid, bus2.rd_data} !== {2'b01, {DW{1'b0}}}) begin
      n_fail++; $display("FAIL oor_rd_lat2: valid %b data %h want 01 / 0",
                         {bus1.rd_valid, bus2.rd_valid}, bus2.rd_data);
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b0, '0, 1'b1, 7'd8, fill(8'hC3), '1);
    drive(1'b1, 7'd8, 1'b1, 7'd8, fill(8'h3C), '1);
    n_checks++;
    if ({bus1.rd_gnt, bus1.wr_gnt, bus2.rd_gnt, bus2.wr_gnt} !== 4'b1111) begin
      n_fail++; $display("FAIL midop_gnt: got %b want 1111",
                         {bus1.rd_gnt, bus1.wr_gnt, bus2.rd_gnt, bus2.wr_gnt});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, '0, '0, '0);
    #1;
    n_checks++;
    if ({bus1.rd_valid, bus2.rd_valid} !== 2'b00) begin
      n_fail++; $display("FAIL midop_valid0: got %b want 00", {bus1.rd_valid, bus2.rd_valid});
    end
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus2.rd_valid, bus1.rd_data, bus2.rd_data} !== {2'b00, {2*DW{1'b0}}}) begin
      n_fail++; $display("FAIL midop_valid1: valid %b data %h / %h want 00 / 0",
                         {bus1.rd_valid, bus2.rd_valid}, bus1.rd_data, bus2.rd_data);
    end
    rst = 1'b0;
    drive(1'b1, 7'd8, 1'b0, '0, '0, '0);
    idle();
    n_checks++;
    if ({bus1.rd_valid, bus1.rd_data} !== {1'b1, fill(8'hC3)}) begin
      n_fail++; $display("FAIL midop_discard_lat1: valid %b data %h want 1 / c3..",
                         bus1.rd_valid, bus1.rd_data);
    end
    idle();
    n_checks++;
    if ({bus2.rd_valid, bus2.rd_data} !== {1'b1, fill(8'hC3)}) begin
      n_fail++; $display("FAIL midop_discard_lat2: valid %b data %h want 1 / c3..",
                         bus2.rd_valid, bus2.rd_data);
    end
  endtask

  initial begin
    set_in(1'b0, '0, 1'b0, '0, '0, '0);
    test_reset();
    test_write_read();
    test_collision();
    test_diff_banks();
    test_starvation();
    test_byte_en_bounds();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
